// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : unified_mem_arbiter                                           |
// | Function : Shares one word-wide memory port between a byte-wide fetch    |
// |            unit and a word load/store data port. Data has priority, a    |
// |            starvation guard bounds fetch wait, and a one-word fetch      |
// |            buffer (kept coherent with stores) serves repeated fetches.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module unified_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [7:0]    i_byte,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  // Counter must hold the value STARVE_LIMIT itself (saturation point).
  localparam int                 c_CNT_W   = $clog2(STARVE_LIMIT + 2);
  localparam logic [c_CNT_W-1:0] c_LIMIT   = c_CNT_W'(STARVE_LIMIT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = {{(c_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_D = 2'd1,
    S_BUSY_I = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_buf_valid;
  logic [AW-3:0]       r_buf_tag;
  logic [31:0]         r_buf_data;
  logic [c_CNT_W-1:0]  r_starve;
  logic [1:0]          r_sel;
  logic                w_hit;
  logic                w_take_hit;
  logic                w_grant_d;
  logic                w_grant_i;
  logic                w_d_done;
  logic                w_i_done;
  logic                w_unused;

  // Data word addresses ignore the byte offset.
  assign w_unused = ^d_addr[1:0];

  assign w_hit    = i_req && r_buf_valid && (r_buf_tag == i_addr[AW-1:2]);
  assign w_d_done = (r_state == S_BUSY_D) && mem_ack;
  assign w_i_done = (r_state == S_BUSY_I) && mem_ack;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and grant decode; arbitration happens only in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_take_hit  = 1'b0;
    w_grant_d   = 1'b0;
    w_grant_i   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_take_hit  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (d_req && (!i_req || (r_starve < c_LIMIT))) begin
          w_grant_d   = 1'b1;
          w_state_nxt = S_BUSY_D;
        end else if (i_req) begin
          w_grant_i   = 1'b1;
          w_state_nxt = S_BUSY_I;
        end
      end
      S_BUSY_D, S_BUSY_I: begin
        if (mem_ack) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Memory port, fetch buffer, starvation counter and completion pulses.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_byte      <= '0;
      i_ready     <= 1'b0;
      d_rdata     <= '0;
      d_ready     <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
      r_starve    <= '0;
      r_sel       <= '0;
    end else begin
      if (w_take_hit) begin
        i_ready <= 1'b1;
        i_byte  <= r_buf_data[{i_addr[1:0], 3'b000} +: 8];
      end else if (w_grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= {d_addr[AW-1:2], 2'b00};
        mem_wdata <= d_wdata;
        // Only consecutive data grants that bypass a waiting fetch count.
        if (!i_req)                    r_starve <= '0;
        else if (r_starve != c_LIMIT)  r_starve <= r_starve + c_CNT_ONE;
      end else if (w_grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= {i_addr[AW-1:2], 2'b00};
        mem_wdata <= '0;
        r_sel     <= i_addr[1:0];
        r_starve  <= '0;
      end

      if (w_d_done) begin
        mem_req <= 1'b0;
        d_ready <= 1'b1;
        d_rdata <= mem_we ? 32'd0 : mem_rdata;
        // Keep the fetch buffer coherent with stores to its word.
        if (mem_we && (mem_addr[AW-1:2] == r_buf_tag)) r_buf_data <= mem_wdata;
      end

      if (w_i_done) begin
        mem_req     <= 1'b0;
        i_ready     <= 1'b1;
        i_byte      <= mem_rdata[{r_sel, 3'b000} +: 8];
        r_buf_valid <= 1'b1;
        r_buf_tag   <= mem_addr[AW-1:2];
        r_buf_data  <= mem_rdata;
      end

      if (r_state == S_DONE) begin
        i_ready <= 1'b0;
        d_ready <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_unified_mem_arbiter                                        |
// | Function : Self-checking bench: transaction-level reference model,       |
// |            directed scenarios and randomized traffic.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_unified_mem_arbiter;

  localparam int c_LIMIT = 4;
  localparam int c_AW    = 32;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            i_req = 1'b0;
  logic [31:0]     i_addr = '0;
  logic [7:0]      i_byte;
  logic            i_ready;
  logic            d_req = 1'b0;
  logic            d_we = 1'b0;
  logic [31:0]     d_addr = '0;
  logic [31:0]     d_wdata = '0;
  logic [31:0]     d_rdata;
  logic            d_ready;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;
  logic            mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  unified_mem_arbiter #(.STARVE_LIMIT(c_LIMIT), .AW(c_AW)) dut (
    .clock(clock), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_byte(i_byte), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] s);
    logic [31:0] t;
    t = w >> (8 * s);
    return t[7:0];
  endfunction

  // ---------------- external memory: 256 words, configurable latency ------
  logic [31:0] mem_arr [0:255];
  bit          zero_wait = 1'b0;
  bit          rand_wait = 1'b0;
  int          fixed_wait = 2;
  int          waitc = 2;
  logic        ack_r = 1'b0;

  assign mem_ack   = zero_wait ? mem_req : ack_r;
  assign mem_rdata = mem_arr[mem_addr[9:2]];

  always @(negedge clock) begin
    if (!resetn) begin
      ack_r = 1'b0;
      waitc = fixed_wait;
    end else if (ack_r) begin
      ack_r = 1'b0;
      waitc = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
    end else if (mem_req && !zero_wait) begin
      if (waitc == 0) ack_r = 1'b1;
      else            waitc--;
    end
  end

  // ---------------- reference model (transaction level) -------------------
  bit          mb_valid;
  logic [29:0] mb_tag;
  logic [31:0] mb_data;
  int          m_starve;
  bit          m_out;
  bit          m_out_fetch;
  logic [31:0] m_out_addr;
  bit          m_out_we;
  logic [31:0] m_out_wdata;
  logic [1:0]  m_out_sel;
  int          m_hold;
  bit          e_i_ready, e_d_ready;
  logic [7:0]  e_i_byte;
  logic [31:0] e_d_rdata;

  // monitor state used by directed scenarios
  logic [31:0] grant_q [$];
  bit          prev_req = 1'b0;
  bit          mreq_seen = 1'b0;

  task automatic model_reset();
    mb_valid = 0; mb_tag = '0; mb_data = '0; m_starve = 0;
    m_out = 0; m_hold = 0; e_i_ready = 0; e_d_ready = 0;
    e_i_byte = '0; e_d_rdata = '0;
  endtask

  initial model_reset();

  // Advance the model on each edge from pre-edge inputs, then compare.
  always @(posedge clock) begin
    if (!resetn) begin
      model_reset();
    end else begin
      e_i_ready = 0;
      e_d_ready = 0;
      if (m_out) begin
        if (mem_ack) begin
          m_out  = 0;
          m_hold = 1;
          if (m_out_fetch) begin
            mb_valid  = 1;
            mb_tag    = m_out_addr[31:2];
            mb_data   = mem_arr[m_out_addr[9:2]];
            e_i_ready = 1;
            e_i_byte  = byte_of(mb_data, m_out_sel);
          end else begin
            e_d_ready = 1;
            e_d_rdata = m_out_we ? 32'd0 : mem_arr[m_out_addr[9:2]];
            if (m_out_we) begin
              if (mb_tag == m_out_addr[31:2]) mb_data = m_out_wdata;
              mem_arr[m_out_addr[9:2]] = m_out_wdata;
            end
          end
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (i_req && mb_valid && mb_tag == i_addr[31:2]) begin
        e_i_ready = 1;
        e_i_byte  = byte_of(mb_data, i_addr[1:0]);
        m_hold    = 1;
      end else if (d_req && (!i_req || m_starve < c_LIMIT)) begin
        m_out = 1; m_out_fetch = 0; m_out_we = d_we;
        m_out_addr = {d_addr[31:2], 2'b00}; m_out_wdata = d_wdata;
        m_starve = i_req ? ((m_starve < c_LIMIT) ? m_starve + 1 : c_LIMIT) : 0;
      end else if (i_req) begin
        m_out = 1; m_out_fetch = 1; m_out_we = 0;
        m_out_addr = {i_addr[31:2], 2'b00}; m_out_sel = i_addr[1:0];
        m_starve = 0;
      end
    end
    #1;
    if (resetn) begin
      chk("mem_req", {31'd0, mem_req}, {31'd0, m_out});
      if (m_out) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, m_out_we});
        chk("mem_addr", mem_addr, m_out_addr);
        if (m_out_we) chk("mem_wdata", mem_wdata, m_out_wdata);
      end
      chk("i_ready", {31'd0, i_ready}, {31'd0, e_i_ready});
      if (e_i_ready) chk("i_byte", {24'd0, i_byte}, {24'd0, e_i_byte});
      chk("d_ready", {31'd0, d_ready}, {31'd0, e_d_ready});
      if (e_d_ready) chk("d_rdata", d_rdata, e_d_rdata);
      if (mem_req) mreq_seen = 1'b1;
      if (mem_req && !prev_req) grant_q.push_back(mem_addr);
    end
    prev_req = resetn && mem_req;
  end

  // ---------------- random requesters -------------------------------------
  bit rand_mode = 1'b0;

  always @(negedge clock) begin
    if (rand_mode && resetn) begin
      if (i_ready || (!i_req && $urandom_range(0, 2) == 0)) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = 32'h100 + $urandom_range(0, 31);
      end
      if (d_ready || (!d_req && $urandom_range(0, 2) == 0)) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = 32'h100 + $urandom_range(0, 31);
        d_wdata = $urandom;
      end
    end
  end

  // ---------------- directed scenarios ------------------------------------
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
  endtask

  // Wait at negedges for a ready pulse; returns cycles waited (bounded).
  task automatic wait_ready(input bit fetch, input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (!(fetch ? i_ready : d_ready) && cycles < 60);
    if (!(fetch ? i_ready : d_ready)) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < 256; k++) mem_arr[k] = $urandom;
    mem_arr[8'h40] = 32'hDDCCBBAA;
    mem_arr[8'h80] = 32'h12345678;
    mem_arr[8'hC0] = 32'hA5A50F1E;
    mem_arr[8'h50] = 32'h00C0FFEE;

    // reset values
    #12;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
    chk("rst_data", {i_byte, d_rdata[23:0]} | {24'd0, d_rdata[31:24]}, 32'd0);
    @(negedge clock); resetn = 1'b1;
    idle(2);

    // fetch miss (2 waits) then buffer hit on the same word
    fixed_wait = 2; waitc = 2;
    i_req = 1; i_addr = 32'h100;
    wait_ready(1, "miss", cyc);
    chk("miss_byte", {24'd0, i_byte}, 32'hAA);
    i_addr = 32'h102; mreq_seen = 0;
    wait_ready(1, "hit", cyc);
    chk("hit_latency", cyc, 2);
    chk("hit_byte", {24'd0, i_byte}, 32'hCC);
    chk("hit_no_mem", {31'd0, mreq_seen}, 32'd0);
    i_req = 0;
    idle(2);

    // simultaneous requests: data first, then fetch
    grant_q.delete();
    d_req = 1; d_we = 0; d_addr = 32'h200;
    i_req = 1; i_addr = 32'h300;
    wait_ready(0, "sim_d", cyc);
    chk("sim_d_rdata", d_rdata, 32'h12345678);
    d_req = 0;
    wait_ready(1, "sim_i", cyc);
    chk("sim_i_byte", {24'd0, i_byte}, 32'h1E);
    i_req = 0;
    chk("sim_grant0", (grant_q.size() > 0) ? grant_q[0] : 32'hFFFFFFFF, 32'h200);
    chk("sim_grant1", (grant_q.size() > 1) ? grant_q[1] : 32'hFFFFFFFF, 32'h300);
    idle(2);

    // starvation: back-to-back loads while a fetch waits
    grant_q.delete();
    d_req = 1; d_we = 0; d_addr = 32'h200;
    i_req = 1; i_addr = 32'h140;
    for (int c = 0; c < 300 && grant_q.size() < 6; c++) begin
      @(negedge clock);
      if (d_ready) d_addr = d_addr + 4;
      if (i_ready) i_req = 0;
    end
    wait_ready(0, "starve_drain", cyc);
    d_req = 0; i_req = 0;
    chk("starve_g3_data", (grant_q.size() > 3) ? grant_q[3] : 32'hFFFFFFFF, 32'h20C);
    chk("starve_g4_fetch", (grant_q.size() > 4) ? grant_q[4] : 32'hFFFFFFFF, 32'h140);
    chk("starve_g5_data", (grant_q.size() > 5) ? grant_q[5] : 32'hFFFFFFFF, 32'h210);
    idle(2);

    // coherence: load word 0x100 into buffer, store to it, fetch hits new data
    i_req = 1; i_addr = 32'h100;
    wait_ready(1, "coh_fill", cyc);
    i_req = 0; idle(1);
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h11223344;
    wait_ready(0, "coh_store", cyc);
    chk("coh_store_rdata", d_rdata, 32'd0);
    d_req = 0; d_we = 0; idle(1);
    mreq_seen = 0;
    i_req = 1; i_addr = 32'h101;
    wait_ready(1, "coh_fetch", cyc);
    chk("coh_byte", {24'd0, i_byte}, 32'h33);
    chk("coh_no_mem", {31'd0, mreq_seen}, 32'd0);
    i_req = 0; idle(2);

    // zero-wait store: d_ready two cycles after the grant cycle
    zero_wait = 1;
    d_req = 1; d_we = 1; d_addr = 32'h204; d_wdata = 32'hCAFEF00D;
    wait_ready(0, "zw", cyc);
    chk("zw_latency", cyc, 2);
    chk("zw_rdata", d_rdata, 32'd0);
    d_req = 0; d_we = 0; zero_wait = 0;
    idle(2);

    // reset while a fetch miss is waiting on memory
    fixed_wait = 5; waitc = 5;
    i_req = 1; i_addr = 32'h300;
    cyc = 0;
    while (!mem_req && cyc < 20) begin @(negedge clock); cyc++; end
    chk("mrst_busy", {31'd0, mem_req}, 32'd1);
    #2 resetn = 1'b0; i_req = 0;
    #1;
    chk("mrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mrst_mem_addr", mem_addr, 32'd0);
    chk("mrst_outs", {i_byte, 22'd0, i_ready, d_ready}, 32'd0);
    @(negedge clock); @(negedge clock); resetn = 1'b1;
    fixed_wait = 1; waitc = 1;
    idle(1);
    mreq_seen = 0;
    i_req = 1; i_addr = 32'h100;
    wait_ready(1, "mrst_refetch", cyc);
    chk("mrst_refetch_mem", {31'd0, mreq_seen}, 32'd1);
    chk("mrst_refetch_byte", {24'd0, i_byte}, 32'h44);
    i_req = 0; idle(2);

    // randomized traffic against the model
    rand_wait = 1;
    rand_mode = 1;
    idle(4000);
    rand_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
